// File: rtl/micro_seq_pkg.sv
// Shared constants for the micro-instruction sequencer: class indices, per-class
// execute lengths and the fetch/capture decode.
package micro_seq_pkg;

    localparam int unsigned FETCH_STEPS = 3;
    localparam int unsigned NUM_CLS     = 10;
    localparam int unsigned MAX_LEN     = 3;

    // LD..DISP indices line up with data_mov bit order, shifted up by one.
    localparam int unsigned CLS_ALU  = 0;
    localparam int unsigned CLS_LD   = 1;
    localparam int unsigned CLS_ST   = 2;
    localparam int unsigned CLS_DATA = 3;
    localparam int unsigned CLS_JMPR = 4;
    localparam int unsigned CLS_JMP  = 5;
    localparam int unsigned CLS_JCON = 6;
    localparam int unsigned CLS_CLR  = 7;
    localparam int unsigned CLS_DISP = 8;
    localparam int unsigned CLS_ILL  = 9;

    localparam int unsigned LEN_ALU  = 3;
    localparam int unsigned LEN_LD   = 2;
    localparam int unsigned LEN_ST   = 2;
    localparam int unsigned LEN_DATA = 3;
    localparam int unsigned LEN_JMPR = 1;
    localparam int unsigned LEN_JMP  = 2;
    localparam int unsigned LEN_JCON = 3;
    localparam int unsigned LEN_CLR  = 1;
    localparam int unsigned LEN_DISP = 1;
    localparam int unsigned LEN_ILL  = 1;

    localparam int unsigned CLS_LEN [NUM_CLS] = '{
        LEN_ALU, LEN_LD, LEN_ST, LEN_DATA, LEN_JMPR,
        LEN_JMP, LEN_JCON, LEN_CLR, LEN_DISP, LEN_ILL
    };

    typedef logic [NUM_CLS-1:0] cls_vec_t;

    // ALU wins outright; otherwise a single data_mov bit selects the class, anything else is illegal.
    function automatic cls_vec_t decode_class(input logic ir_alu, input logic [7:0] dm);
        logic dm_onehot;
        dm_onehot = (dm != 8'h00) && ((dm & (dm - 8'd1)) == 8'h00);
        if (ir_alu) begin
            decode_class = NUM_CLS'(1) << CLS_ALU;
        end else if (dm_onehot) begin
            decode_class = {1'b0, dm, 1'b0};
        end else begin
            decode_class = NUM_CLS'(1) << CLS_ILL;
        end
    endfunction

endpackage

// File: rtl/step_ring.sv
// One-hot step ring: advances on en, returns to step 1 when wrap is asserted.
module step_ring #(
    parameter int unsigned NUM_STEPS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 wrap,
    output logic [NUM_STEPS-1:0] step
);

    logic [NUM_STEPS-1:0] step_q;
    logic [NUM_STEPS-1:0] step_d;

    always_comb begin
        step_d = step_q;
        if (en) begin
            step_d = wrap ? NUM_STEPS'(1) : (step_q << 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= NUM_STEPS'(1);
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/micro_sequencer.sv
// Micro-instruction sequencer: step ring, class capture at end of fetch, and the
// step-qualified control-strobe AND-plane.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 6,
    parameter bit          EARLY_END = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [7:0]           IR,
    input  logic [7:0]           data_mov,
    input  logic                 flag,
    output logic [NUM_STEPS-1:0] step,
    output logic                 fetch,
    output logic [2:0]           cpt,
    output logic [1:0]           ld,
    output logic [1:0]           st,
    output logic [1:0]           jmp,
    output logic [2:0]           data,
    output logic [2:0]           jcon,
    output logic                 jmpr,
    output logic                 clr,
    output logic                 disp,
    output logic                 illegal,
    output logic                 instr_done
);

    cls_vec_t             cls_q;
    cls_vec_t             cls_d;
    logic [NUM_CLS-1:0]   last_hit;
    logic                 wrap;

    step_ring #(
        .NUM_STEPS (NUM_STEPS)
    ) u_step_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .wrap  (wrap),
        .step  (step)
    );

    // Class is sampled only on the enabled edge leaving the last fetch step.
    always_comb begin
        cls_d = cls_q;
        if (step[FETCH_STEPS-1] && en) begin
            cls_d = decode_class(IR[7], data_mov);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q <= '0;
        end else begin
            cls_q <= cls_d;
        end
    end

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_last
        localparam int unsigned LAST_IDX = FETCH_STEPS + CLS_LEN[c] - 1;
        assign last_hit[c] = cls_q[c] & step[LAST_IDX];
    end

    // The final ring step always ends the instruction, whatever the class.
    assign instr_done = step[NUM_STEPS-1] | (EARLY_END & (|last_hit));
    assign wrap       = instr_done;

    assign fetch   = |step[FETCH_STEPS-1:0];
    assign cpt     = {3{cls_q[CLS_ALU]}}  & step[FETCH_STEPS +: 3];
    assign ld      = {2{cls_q[CLS_LD]}}   & step[FETCH_STEPS +: 2];
    assign st      = {2{cls_q[CLS_ST]}}   & step[FETCH_STEPS +: 2];
    assign jmp     = {2{cls_q[CLS_JMP]}}  & step[FETCH_STEPS +: 2];
    assign data    = {3{cls_q[CLS_DATA]}} & step[FETCH_STEPS +: 3];
    // Last JCON strobe follows the live flag with no latching.
    assign jcon    = {cls_q[CLS_JCON] & step[FETCH_STEPS + 2] & flag,
                      {2{cls_q[CLS_JCON]}} & step[FETCH_STEPS +: 2]};
    assign jmpr    = cls_q[CLS_JMPR] & step[FETCH_STEPS];
    assign clr     = cls_q[CLS_CLR]  & step[FETCH_STEPS];
    assign disp    = cls_q[CLS_DISP] & step[FETCH_STEPS];
    assign illegal = cls_q[CLS_ILL]  & step[FETCH_STEPS];

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: one EARLY_END=1/6-step instance and one
// legacy-timing 8-step instance, checked with immediate assertions.
module tb_micro_sequencer;

    localparam int B_ILL  = 0;
    localparam int B_DISP = 1;
    localparam int B_CLR  = 2;
    localparam int B_JMPR = 3;
    localparam int B_JCON = 4;
    localparam int B_DATA = 7;
    localparam int B_JMP  = 10;
    localparam int B_ST   = 12;
    localparam int B_LD   = 14;
    localparam int B_CPT  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, flag, en_b, flag_b;
    logic [7:0] ir, dm, ir_b, dm_b;

    logic [5:0] step_a;
    logic       fetch_a, jmpr_a, clr_a, disp_a, ill_a, done_a;
    logic [2:0] cpt_a, data_a, jcon_a;
    logic [1:0] ld_a, st_a, jmp_a;

    logic [7:0] step_b;
    logic       fetch_b, jmpr_b, clr_b, disp_b, ill_b, done_b;
    logic [2:0] cpt_b, data_b, jcon_b;
    logic [1:0] ld_b, st_b, jmp_b;

    wire [18:0] strb_a = {cpt_a, ld_a, st_a, jmp_a, data_a, jcon_a, jmpr_a, clr_a, disp_a, ill_a};
    wire [18:0] strb_b = {cpt_b, ld_b, st_b, jmp_b, data_b, jcon_b, jmpr_b, clr_b, disp_b, ill_b};

    int vectors     = 0;
    int miscompares = 0;

    micro_sequencer #(.NUM_STEPS(6), .EARLY_END(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .IR(ir), .data_mov(dm), .flag(flag),
        .step(step_a), .fetch(fetch_a), .cpt(cpt_a), .ld(ld_a), .st(st_a), .jmp(jmp_a),
        .data(data_a), .jcon(jcon_a), .jmpr(jmpr_a), .clr(clr_a), .disp(disp_a),
        .illegal(ill_a), .instr_done(done_a)
    );

    micro_sequencer #(.NUM_STEPS(8), .EARLY_END(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .IR(ir_b), .data_mov(dm_b), .flag(flag_b),
        .step(step_b), .fetch(fetch_b), .cpt(cpt_b), .ld(ld_b), .st(st_b), .jmp(jmp_b),
        .data(data_b), .jcon(jcon_b), .jmpr(jmpr_b), .clr(clr_b), .disp(disp_b),
        .illegal(ill_b), .instr_done(done_b)
    );

    function automatic logic [18:0] sb(input int base, input int k);
        sb = 19'(1) << (base + k);
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [5:0] s, input logic d, input logic [18:0] strb);
        cmp({tag, "/step"},  32'(step_a),  32'(s));
        cmp({tag, "/fetch"}, 32'(fetch_a), 32'(|s[2:0]));
        cmp({tag, "/done"},  32'(done_a),  32'(d));
        cmp({tag, "/strb"},  32'(strb_a),  32'(strb));
    endtask

    task automatic chk_b(input string tag, input logic [7:0] s, input logic d, input logic [18:0] strb);
        cmp({tag, "/step"},  32'(step_b),  32'(s));
        cmp({tag, "/fetch"}, 32'(fetch_b), 32'(|s[2:0]));
        cmp({tag, "/done"},  32'(done_b),  32'(d));
        cmp({tag, "/strb"},  32'(strb_b),  32'(strb));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; flag = 1'b0; ir = 8'h00; dm = 8'h00;
        en_b = 1'b0; flag_b = 1'b0; ir_b = 8'h00; dm_b = 8'h08;

        tick(); tick();
        chk_a("reset", 6'b000001, 1'b0, 19'h0);
        chk_b("reset_b", 8'h01, 1'b0, 19'h0);
        rst_n = 1'b1;

        // ALU: cpt on steps 4/5/6, wrap after 6 cycles
        ir = 8'h80; en = 1'b1;
        chk_a("alu_s1", 6'b000001, 1'b0, 19'h0);
        tick(); chk_a("alu_s2", 6'b000010, 1'b0, 19'h0);
        tick(); chk_a("alu_s3", 6'b000100, 1'b0, 19'h0);
        tick(); chk_a("alu_s4", 6'b001000, 1'b0, sb(B_CPT, 0));
        tick(); chk_a("alu_s5", 6'b010000, 1'b0, sb(B_CPT, 1));
        tick(); chk_a("alu_s6", 6'b100000, 1'b1, sb(B_CPT, 2));
        tick(); chk_a("alu_s7", 6'b000001, 1'b0, 19'h0);

        // JCON: flag raised during step 6 shows up without a clock edge
        ir = 8'h00; dm = 8'h20;
        tick(); chk_a("jcon_s2", 6'b000010, 1'b0, 19'h0);
        tick(); chk_a("jcon_s3", 6'b000100, 1'b0, 19'h0);
        tick(); chk_a("jcon_s4", 6'b001000, 1'b0, sb(B_JCON, 0));
        tick(); chk_a("jcon_s5", 6'b010000, 1'b0, sb(B_JCON, 1));
        tick(); chk_a("jcon_s6f0", 6'b100000, 1'b1, 19'h0);
        flag = 1'b1; #1;
        chk_a("jcon_s6f1", 6'b100000, 1'b1, sb(B_JCON, 2));
        flag = 1'b0;
        tick(); chk_a("jcon_s7", 6'b000001, 1'b0, 19'h0);

        // JMPR: 4-cycle instruction
        dm = 8'h08;
        tick(); tick();
        tick(); chk_a("jmpr_s4", 6'b001000, 1'b1, sb(B_JMPR, 0));
        tick(); chk_a("jmpr_s5", 6'b000001, 1'b0, 19'h0);

        // Two data_mov bits: illegal
        dm = 8'h11;
        tick(); tick();
        tick(); chk_a("ill2_s4", 6'b001000, 1'b1, sb(B_ILL, 0));
        tick(); chk_a("ill2_s5", 6'b000001, 1'b0, 19'h0);

        // No data_mov bits: illegal
        dm = 8'h00;
        tick(); tick();
        tick(); chk_a("ill0_s4", 6'b001000, 1'b1, sb(B_ILL, 0));
        tick(); chk_a("ill0_s5", 6'b000001, 1'b0, 19'h0);

        // IR[7] overrides data_mov
        ir = 8'h80; dm = 8'h01;
        tick(); tick();
        tick(); chk_a("alup_s4", 6'b001000, 1'b0, sb(B_CPT, 0));
        tick(); chk_a("alup_s5", 6'b010000, 1'b0, sb(B_CPT, 1));
        tick(); chk_a("alup_s6", 6'b100000, 1'b1, sb(B_CPT, 2));
        tick(); chk_a("alup_s7", 6'b000001, 1'b0, 19'h0);

        // ST: 5-cycle instruction
        ir = 8'h00; dm = 8'h02;
        tick(); tick();
        tick(); chk_a("st_s4", 6'b001000, 1'b0, sb(B_ST, 0));
        tick(); chk_a("st_s5", 6'b010000, 1'b1, sb(B_ST, 1));
        tick(); chk_a("st_s6", 6'b000001, 1'b0, 19'h0);

        // LD with en held low at step 4; IR/data_mov changes are ignored
        dm = 8'h01;
        tick(); tick();
        tick(); chk_a("ld_s4", 6'b001000, 1'b0, sb(B_LD, 0));
        en = 1'b0; ir = 8'h80; dm = 8'h04;
        tick(); chk_a("ld_hold1", 6'b001000, 1'b0, sb(B_LD, 0));
        tick(); chk_a("ld_hold2", 6'b001000, 1'b0, sb(B_LD, 0));
        tick(); chk_a("ld_hold3", 6'b001000, 1'b0, sb(B_LD, 0));
        en = 1'b1;
        tick(); chk_a("ld_s5", 6'b010000, 1'b1, sb(B_LD, 1));
        tick(); chk_a("ld_s6", 6'b000001, 1'b0, 19'h0);

        // Capture waits for the first enabled edge leaving step 3
        ir = 8'h00; dm = 8'h08;
        tick(); tick();
        en = 1'b0; dm = 8'h80;
        tick(); chk_a("cap_hold", 6'b000100, 1'b0, 19'h0);
        en = 1'b1;
        tick(); chk_a("cap_s4", 6'b001000, 1'b1, sb(B_DISP, 0));
        tick(); chk_a("cap_s5", 6'b000001, 1'b0, 19'h0);

        // DATA, then asynchronous reset during step 5
        dm = 8'h04;
        tick(); tick();
        tick(); chk_a("data_s4", 6'b001000, 1'b0, sb(B_DATA, 0));
        tick(); chk_a("data_s5", 6'b010000, 1'b0, sb(B_DATA, 1));
        #1 rst_n = 1'b0;
        #1 chk_a("rst_async", 6'b000001, 1'b0, 19'h0);
        tick();
        rst_n = 1'b1;
        chk_a("rst_rel", 6'b000001, 1'b0, 19'h0);
        en = 1'b0;

        // Legacy timing, 8 steps: JMPR strobes only at step 4, done only at step 8
        en_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_b($sformatf("legacy_s%0d", i + 1), 8'(1) << i, (i == 7), (i == 3) ? sb(B_JMPR, 0) : 19'h0);
            tick();
        end
        chk_b("legacy_wrap", 8'h01, 1'b0, 19'h0);
        en_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
